// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types and constants for the instruction-memory loader
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        HOLD,
        RUN,
        ERR
    } state_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
    localparam int         LEN_W             = 16;

    // A frame may fill the memory exactly but never exceed it.
    function automatic logic len_too_big(input logic [LEN_W-1:0] len, input int addr_w);
        return 32'(len) > (32'd1 << addr_w);
    endfunction

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - packs four bytes, most-significant first, into a 32-bit word
module byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  byte_in,
    input  logic        strobe,
    input  logic        clear,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  idx;
    logic [23:0] shift;

    // The word completes combinationally on the fourth byte so the loader can
    // register the write on the very same edge.
    assign word_valid = strobe && !clear && (idx == 2'd3);
    assign word       = {shift, byte_in};

    // Byte index and shift register; clear drops any partial word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx   <= 2'd0;
            shift <= 24'd0;
        end else if (clear) begin
            idx   <= 2'd0;
        end else if (strobe) begin
            idx   <= idx + 2'd1;
            shift <= {shift[15:0], byte_in};
        end
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader writing a framed byte stream into instruction memory
module imem_loader
    import loader_pkg::*;
#(
    parameter int         ADDR_W    = 10,
    parameter int         RST_HOLD  = 4,
    parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   word_cnt
);

    localparam logic [7:0]    HOLD_LOAD = 8'(RST_HOLD - 1);
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

    state_t           state;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] len_next;
    logic [7:0]       hold_cnt;
    logic             xfer;
    logic [31:0]      packed_word;
    logic             word_valid;
    logic [ADDR_W:0]  cnt_inc;

    assign xfer     = rx_valid && rx_ready;
    assign len_next = {len[15:8], rx_data};
    assign cnt_inc  = word_cnt + CNT_ONE;

    byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .byte_in    (rx_data),
        .strobe     (xfer && (state == DATA)),
        .clear      (state != DATA),
        .word       (packed_word),
        .word_valid (word_valid)
    );

    // Frame FSM; every output is registered alongside the transition that sets it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            len       <= '0;
            hold_cnt  <= 8'd0;
            rx_ready  <= 1'b0;
            im_we     <= 1'b0;
            im_addr   <= '0;
            im_wdata  <= 32'd0;
            cpu_reset <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            word_cnt  <= '0;
        end else begin
            im_we <= 1'b0;
            case (state)
                IDLE: begin
                    rx_ready <= 1'b1;
                    if (xfer && rx_data == SYNC_BYTE) begin
                        state <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (xfer) begin
                        len[15:8] <= rx_data;
                        state     <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (xfer) begin
                        len[7:0] <= rx_data;
                        if (len_next == '0) begin
                            state    <= HOLD;
                            rx_ready <= 1'b0;
                            hold_cnt <= HOLD_LOAD;
                        end else if (len_too_big(len_next, ADDR_W)) begin
                            state    <= ERR;
                            rx_ready <= 1'b0;
                            load_err <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (word_valid) begin
                        im_we    <= 1'b1;
                        im_addr  <= word_cnt[ADDR_W-1:0];
                        im_wdata <= packed_word;
                        word_cnt <= cnt_inc;
                        if (LEN_W'(cnt_inc) == len) begin
                            state    <= HOLD;
                            rx_ready <= 1'b0;
                            hold_cnt <= HOLD_LOAD;
                        end
                    end
                end
                HOLD: begin
                    if (hold_cnt == 8'd0) begin
                        state     <= RUN;
                        cpu_reset <= 1'b0;
                        load_done <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt - 8'd1;
                    end
                end
                default: begin
                    // RUN and ERR hold until reset.
                end
            endcase
        end
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the single-cycle CPU's instruction memory: receives a framed byte stream, packs bytes into 32-bit words and writes them sequentially into the IFU instruction memory write port.
- Holds the CPU in reset until the load completes, then releases it.
- Sits between a byte source (UART receiver or bench driver) and the IFU memory. It replaces the simulation-only hex preload with a synthesizable load path.

Parameters:
- ADDR_W, 10, word-address width of instruction memory (depth = 2**ADDR_W words)
- RST_HOLD, 4, cycles cpu_reset stays high after the last write (legal range 1..255)
- SYNC_BYTE, 8'hA5, frame start marker

Ports:
- clk  input  1  system clock, rising-edge
- reset  input  1  asynchronous, active-high reset
- rx_data  input  8  incoming byte
- rx_valid  input  1  rx_data valid
- rx_ready  output  1  loader can accept a byte; transfer occurs when rx_valid && rx_ready at a rising edge
- im_we  output  1  instruction-memory write strobe, one-cycle pulse per word
- im_addr  output  ADDR_W  word address of the write
- im_wdata  output  32  word to write
- cpu_reset  output  1  reset to the CPU core, active-high
- load_done  output  1  load finished and CPU released
- load_err  output  1  frame rejected (length too large)
- word_cnt  output  ADDR_W+1  words written so far

Behaviour:
- One clock domain: clk. Reset is asynchronous and active-high on reset. All state clears immediately on reset assertion.
- Reset values:
  - cpu_reset=1.
  - rx_ready=0, im_we=0, im_addr=0, im_wdata=0, load_done=0, load_err=0, word_cnt=0.
  - State is IDLE.
- Frame format, in order:
  - SYNC_BYTE.
  - LEN_HI, LEN_LO: 16-bit word count, big-endian.
  - LEN words, each sent as 4 bytes, most-significant byte first.
- States and transitions:
  - IDLE: rx_ready=1. A byte equal to SYNC_BYTE moves to LEN_HI. Any other byte is discarded and the state stays IDLE.
  - LEN_HI: rx_ready=1. The accepted byte is stored as len[15:8]; move to LEN_LO.
  - LEN_LO: rx_ready=1. The accepted byte is stored as len[7:0], then:
    - len==0 goes to HOLD.
    - len>2**ADDR_W goes to ERR.
    - Otherwise go to DATA.
  - DATA: rx_ready=1. A 2-bit byte index counts 0..3 and shifts bytes into the packer. On the handshake of byte index 3:
    - im_we=1 on the next cycle, with im_addr=word index and im_wdata={b0,b1,b2,b3}.
    - The word index increments and word_cnt increments in that same cycle.
    - When the handshake completes word number len, the state moves to HOLD. The final im_we pulse occurs in the first HOLD cycle.
  - HOLD: rx_ready=0, cpu_reset=1. A counter runs RST_HOLD cycles, then the state moves to RUN.
  - RUN: cpu_reset=0, load_done=1, rx_ready=0. This state is terminal until reset.
  - ERR: load_err=1, cpu_reset=1, rx_ready=0. This state is terminal until reset. No writes are issued.
- Latency: 1 cycle from the 4th byte handshake to the im_we pulse. CPU release comes RST_HOLD cycles after entering HOLD.
- Gaps in rx_valid are allowed anywhere. The byte index and length are preserved across gaps. There is no timeout.
- A len of exactly 2**ADDR_W is legal. The last write address is 2**ADDR_W-1, and the address must not wrap before the final write.
- Reset asserted mid-frame:
  - Partial words are discarded.
  - Already-written memory contents are not cleared.
  - The loader returns to IDLE with cpu_reset=1.
- im_we is never high for two consecutive cycles, because each word needs at least 4 byte handshakes.

Decomposition:
- Package loader_pkg:
  - state enum {IDLE, LEN_HI, LEN_LO, DATA, HOLD, RUN, ERR}.
  - SYNC_BYTE default.
  - Frame-length width constant LEN_W=16.
- Sub-module byte_packer:
  - Inputs: clk, reset, byte in, strobe, clear.
  - Behaviour: 2-bit index, 32-bit shift register, word_valid pulse on the 4th byte.
- The FSM, word index, hold counter and output registers stay in imem_loader.

Test Plan:
- Basic load: bytes A5 00 02 24 01 00 05 8C 22 00 00 sent back-to-back.
  - Write im[0]=0x24010005, then im[1]=0x8C220000.
  - word_cnt=2; cpu_reset falls RST_HOLD cycles later; load_done=1.
- Sync hunt: bytes 00 FF 5A, then A5 00 01 DE AD BE EF.
  - Leading bytes are ignored; a single write im[0]=0xDEADBEEF; load_done=1.
- Zero length: A5 00 00.
  - No im_we; HOLD then RUN; word_cnt=0; cpu_reset low after RST_HOLD cycles.
- Oversize: with ADDR_W=10, send A5 04 01 (len=1025).
  - load_err=1, rx_ready=0, cpu_reset stays 1, no im_we.
- Backpressure/gaps: the basic frame with rx_valid low for 3 random cycles between each byte.
  - Identical writes and values to the basic load; rx_ready=0 after the last byte.
- Reset mid-load: assert reset after 6 bytes of the basic frame, then replay the full frame.
  - cpu_reset=1 and IDLE immediately on reset; the replay yields the same two writes and load_done=1.
